apb_mem_slave: RTL and testbench

APB_MEM_SLAVE -- requirements
Module: apb_mem_slave

---
 rtl/apb_mem_slave.sv | 83 ++++++++
 tb/tb_apb_mem_slave.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/apb_mem_slave.sv
// apb_mem_slave: APB-style memory slave with programmable wait states.
// Define APB_MEM_ERR_EN to add the error_o address-error output.
module apb_mem_slave #(
  parameter int WIDTH       = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic                  wr_rd_i,
  input  logic                  valid_i,
  output logic [WIDTH-1:0]      rdata_o,
  output logic                  ready_o
`ifdef APB_MEM_ERR_EN
  ,
  output logic                  error_o
`endif
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_t;
  state_t                state;
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [WIDTH-1:0]      wdata_q;
  logic                  wr_q;
  logic [WIDTH-1:0]      mem [DEPTH];
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  sel_wr;
  logic                  sel_oob;
  logic                  go_access;
  logic [WIDTH-1:0]      sel_rdata;
  // In IDLE with WAIT_CYCLES=0 the access is set up straight from the inputs
  always_comb begin
    sel_addr  = state == S_IDLE ? addr_i : addr_q;
    sel_wr    = state == S_IDLE ? wr_rd_i : wr_q;
    sel_oob   = {1'b0, sel_addr} >= DEPTH_W;
    sel_rdata = sel_oob ? '0 : mem[sel_addr[IW-1:0]];
    go_access = (state == S_IDLE && valid_i && WAIT_CYCLES == 0) || (state == S_WAIT && cnt == 4'd0);
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= S_IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      ready_o <= 1'b0;
      rdata_o <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      ready_o <= go_access;
      if (go_access && !sel_wr) rdata_o <= sel_rdata;
      case (state)
        S_IDLE: if (valid_i) begin
          addr_q  <= addr_i;
          wdata_q <= wdata_i;
          wr_q    <= wr_rd_i;
          cnt     <= WAIT_CYCLES == 0 ? 4'd0 : 4'(WAIT_CYCLES - 1);
          state   <= WAIT_CYCLES == 0 ? S_ACCESS : S_WAIT;
        end
        S_WAIT: begin
          cnt   <= cnt == 4'd0 ? 4'd0 : cnt - 4'd1;
          state <= cnt == 4'd0 ? S_ACCESS : S_WAIT;
        end
        S_ACCESS: begin
          state <= S_IDLE;
          if (wr_q && !sel_oob) mem[addr_q[IW-1:0]] <= wdata_q;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
`ifdef APB_MEM_ERR_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) error_o <= 1'b0;
    else error_o <= go_access && sel_oob;
  end
`endif
endmodule

// File: tb/tb_apb_mem_slave.sv
// tb_apb_mem_slave: scoreboard bench for apb_mem_slave with a word-array reference model.
module tb_apb_mem_slave;
  localparam int WIDTH = 32, AW = 8, DEPTH = 64, W = 2;
  logic             clk_i = 1'b0;
  logic             rst_i = 1'b0;
  logic [AW-1:0]    addr_i = '0;
  logic [WIDTH-1:0] wdata_i = '0;
  logic             wr_rd_i = 1'b0;
  logic             valid_i = 1'b0;
  logic [WIDTH-1:0] rdata_o;
  logic             ready_o;
`ifdef APB_MEM_ERR_EN
  logic             error_o;
`endif
  apb_mem_slave #(.WIDTH(WIDTH), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .addr_i(addr_i), .wdata_i(wdata_i), .wr_rd_i(wr_rd_i),
    .valid_i(valid_i), .rdata_o(rdata_o), .ready_o(ready_o)
`ifdef APB_MEM_ERR_EN
    , .error_o(error_o)
`endif
  );
  always #5 clk_i = ~clk_i;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;
  typedef struct {
    bit               rd;
    logic [WIDTH-1:0] data;
    bit               err;
    int               cyc;
  } exp_t;
  exp_t             sb[$];
  logic [WIDTH-1:0] mem_model [DEPTH];
  logic [WIDTH-1:0] held = '0;
  int               tests = 0, fails = 0;
  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) mem_model[i] = '0;
  endtask
  // Issue one transfer, predict its response, then scramble inputs while it is in flight
  task automatic xfer(input bit wr, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    exp_t e;
    int   ai;
    ai = int'(a);
    @(negedge clk_i);
    valid_i = 1'b1; wr_rd_i = wr; addr_i = a; wdata_i = d;
    @(posedge clk_i);
    #1;
    e.rd   = !wr;
    e.err  = ai >= DEPTH;
    e.cyc  = cyc + W;
    e.data = (!wr && ai < DEPTH) ? mem_model[ai] : '0;
    if (wr && ai < DEPTH) mem_model[ai] = d;
    sb.push_back(e);
    repeat (W + 1) begin
      @(negedge clk_i);
      valid_i = 1'($urandom); wr_rd_i = 1'($urandom); addr_i = AW'($urandom); wdata_i = $urandom;
      @(posedge clk_i);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_i);
      valid_i = 1'b0; addr_i = AW'($urandom); wdata_i = $urandom; wr_rd_i = 1'($urandom);
    end
  endtask
  always @(negedge clk_i) begin
    exp_t e;
    if (rst_i) begin
      held = '0;
      sb.delete();
      tests++;
      if (ready_o !== 1'b0 || rdata_o !== '0) begin
        fails++;
        $display("FAIL reset_outputs: ready=%b rdata=%h, required ready=0 rdata=0", ready_o, rdata_o);
      end
    end else if (ready_o === 1'b1) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_ready: ready pulse at cycle %0d with nothing outstanding", cyc);
      end else begin
        e = sb.pop_front();
        if (cyc != e.cyc) begin
          fails++;
          $display("FAIL latency: ready at cycle %0d, required cycle %0d", cyc, e.cyc);
        end
        if (e.rd) held = e.data;
        tests++;
        if (rdata_o !== held) begin
          fails++;
          $display("FAIL rdata_%s: got %h, required %h", e.rd ? "read" : "write", rdata_o, held);
        end
`ifdef APB_MEM_ERR_EN
        tests++;
        if (error_o !== e.err) begin
          fails++;
          $display("FAIL error_access: got %b, required %b", error_o, e.err);
        end
`endif
      end
    end else begin
      tests++;
      if (rdata_o !== held) begin
        fails++;
        $display("FAIL rdata_hold: got %h, required %h at cycle %0d", rdata_o, held, cyc);
      end
`ifdef APB_MEM_ERR_EN
      tests++;
      if (error_o !== 1'b0) begin
        fails++;
        $display("FAIL error_idle: got %b, required 0", error_o);
      end
`endif
    end
  end
  initial begin
    clear_model();
    #1 rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    xfer(1'b1, 8'h05, 32'hDEADBEEF);
    xfer(1'b0, 8'h05, '0);
    idle(3);
    xfer(1'b1, 8'h00, 32'h11);
    xfer(1'b1, 8'h01, 32'h22);
    xfer(1'b1, 8'h02, 32'h33);
    xfer(1'b0, 8'h00, '0);
    xfer(1'b0, 8'h01, '0);
    xfer(1'b0, 8'h02, '0);
    idle(2);
    xfer(1'b1, 8'h40, 32'hAA);
    xfer(1'b0, 8'h40, '0);
    xfer(1'b0, 8'h05, '0);
    idle(1);
    // Abort a write mid-WAIT with an asynchronous reset pulse
    @(negedge clk_i);
    valid_i = 1'b1; wr_rd_i = 1'b1; addr_i = 8'h03; wdata_i = 32'h55;
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b0;
    @(posedge clk_i);
    #2 rst_i = 1'b1;
    clear_model();
    #1;
    tests++;
    if (ready_o !== 1'b0 || rdata_o !== '0) begin
      fails++;
      $display("FAIL async_reset: ready=%b rdata=%h, required ready=0 rdata=0", ready_o, rdata_o);
    end
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    xfer(1'b0, 8'h03, '0);
    xfer(1'b0, 8'h05, '0);
    repeat (60) begin
      xfer(1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH + 15)), $urandom);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    for (int i = 0; i < 8; i++) xfer(1'b0, AW'(i), '0);
    idle(W + 4);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL timeout: %0d transfers never completed, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
